// File: rtl/echo_indication_portal.sv
// Echo indication portal: buffers echo payloads and sends each one to the
// host pipe as a two-word message (header, payload).
//
// Ports:
//   CLK, nRST           clock, synchronous active-low reset
//   echo__RDY/ENA, v    echo method call (ENA/RDY), 32-bit payload
//   pipe_enq__RDY/ENA,v host-bound pipe enq call, 32-bit word
//   msg_count           complete messages sent, wraps modulo 2^32
module echo_indication_portal #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] METHOD_ID = 16'h0001
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        echo__RDY,
  input  logic        echo__ENA,
  input  logic [31:0] echo_v,
  input  logic        pipe_enq__RDY,
  output logic        pipe_enq__ENA,
  output logic [31:0] pipe_enq_v,
  output logic [31:0] msg_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    HDR,
    DATA
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   msg_cnt_q;
  logic          active;
  logic          push;
  logic          pop;

  assign echo__RDY = (count != (AW+1)'(DEPTH));
  assign push      = echo__ENA && echo__RDY;
  assign msg_count = msg_cnt_q;

  // Only the payload word pops the FIFO; the header merely peeks,
  // so DATA is never entered with an empty FIFO.
  assign pop = pipe_enq__ENA && (state == DATA);

  always_comb begin
    state_n    = state;
    active     = 1'b0;
    pipe_enq_v = 32'd0;
    unique case (state)
      HDR: begin
        active = (count != '0);
        if (active) begin
          pipe_enq_v = {METHOD_ID, 16'd2};
        end
      end
      DATA: begin
        active     = 1'b1;
        pipe_enq_v = mem[rd_ptr];
      end
    endcase
    pipe_enq__ENA = active && pipe_enq__RDY;
    if (pipe_enq__ENA) begin
      state_n = (state == HDR) ? DATA : HDR;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= echo_v;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= HDR;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      msg_cnt_q <= 32'd0;
    end else begin
      state <= state_n;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        msg_cnt_q <= msg_cnt_q + 32'd1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_indication_portal.sv
// Directed self-checking bench for echo_indication_portal.
// Checks reset, message framing, fill/back-pressure, wrap and reset flush.
module tb_echo_indication_portal;

  localparam logic [31:0] HW = 32'h0001_0002;

  logic        CLK;
  logic        nRST;
  logic        echo__RDY;
  logic        echo__ENA;
  logic [31:0] echo_v;
  logic        pipe_enq__RDY;
  logic        pipe_enq__ENA;
  logic [31:0] pipe_enq_v;
  logic [31:0] msg_count;

  int n_chk;
  int n_err;

  echo_indication_portal #(
    .DEPTH(4),
    .METHOD_ID(16'h0001)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .echo__RDY(echo__RDY),
    .echo__ENA(echo__ENA),
    .echo_v(echo_v),
    .pipe_enq__RDY(pipe_enq__RDY),
    .pipe_enq__ENA(pipe_enq__ENA),
    .pipe_enq_v(pipe_enq_v),
    .msg_count(msg_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    echo__ENA     = 1'b0;
    echo_v        = 32'd0;
    pipe_enq__RDY = 1'b0;
    nRST          = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic push(input logic [31:0] v);
    echo__ENA = 1'b1;
    echo_v    = v;
    tick();
    echo__ENA = 1'b0;
  endtask

  logic [31:0] exp_w [20];
  int          idx;
  int          nxt;
  bit          pushed;

  initial begin
    n_chk = 0;
    n_err = 0;

    // reset state
    do_reset();
    pipe_enq__RDY = 1'b1;
    settle();
    chk("rst_rdy", 32'(echo__RDY), 32'd1);
    chk("rst_ena", 32'(pipe_enq__ENA), 32'd0);
    chk("rst_v", pipe_enq_v, 32'd0);
    chk("rst_cnt", msg_count, 32'd0);

    // single message
    push(32'hDEADBEEF);
    settle();
    chk("t1_hdr_ena", 32'(pipe_enq__ENA), 32'd1);
    chk("t1_hdr_v", pipe_enq_v, HW);
    tick();
    settle();
    chk("t1_dat_ena", 32'(pipe_enq__ENA), 32'd1);
    chk("t1_dat_v", pipe_enq_v, 32'hDEADBEEF);
    tick();
    settle();
    chk("t1_cnt", msg_count, 32'd1);
    chk("t1_idle", 32'(pipe_enq__ENA), 32'd0);

    // fill to full under back-pressure
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      echo__ENA = 1'b1;
      echo_v    = 32'(i);
      settle();
      chk("fill_rdy", 32'(echo__RDY), 32'd1);
      chk("fill_bp", 32'(pipe_enq__ENA), 32'd0);
      tick();
    end
    echo__ENA = 1'b1;
    echo_v    = 32'd5;
    settle();
    chk("full_rdy", 32'(echo__RDY), 32'd0);
    tick();
    echo__ENA = 1'b0;
    pipe_enq__RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_w[2*i]   = HW;
      exp_w[2*i+1] = 32'(i + 1);
    end
    idx = 0;
    for (int k = 0; k < 20 && idx < 8; k++) begin
      settle();
      if (pipe_enq__ENA) begin
        chk("fill_word", pipe_enq_v, exp_w[idx]);
        idx++;
      end
      tick();
    end
    chk("fill_len", 32'(idx), 32'd8);
    settle();
    chk("fill_nodrop5", 32'(pipe_enq__ENA), 32'd0);
    chk("fill_cnt", msg_count, 32'd4);

    // back-pressure mid-message
    do_reset();
    pipe_enq__RDY = 1'b1;
    push(32'h12345678);
    settle();
    chk("bp_hdr", pipe_enq_v, HW);
    tick();
    pipe_enq__RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_ena", 32'(pipe_enq__ENA), 32'd0);
      chk("bp_hold", pipe_enq_v, 32'h12345678);
      tick();
    end
    pipe_enq__RDY = 1'b1;
    settle();
    chk("bp_go", 32'(pipe_enq__ENA), 32'd1);
    chk("bp_word", pipe_enq_v, 32'h12345678);
    tick();
    settle();
    chk("bp_once", 32'(pipe_enq__ENA), 32'd0);
    chk("bp_cnt", msg_count, 32'd1);

    // simultaneous enq/deq with pointer wrap
    do_reset();
    push(32'd0);
    push(32'd1);
    pipe_enq__RDY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_w[2*i]   = HW;
      exp_w[2*i+1] = 32'(i);
    end
    idx = 0;
    nxt = 2;
    for (int k = 0; k < 40 && idx < 20; k++) begin
      pushed    = (k % 2 == 1) && (nxt <= 9);
      echo__ENA = pushed;
      echo_v    = 32'(nxt);
      settle();
      if (pushed) begin
        chk("sim_rdy", 32'(echo__RDY), 32'd1);
        chk("sim_count", 32'(dut.count), 32'd2);
      end
      if (pipe_enq__ENA) begin
        chk("sim_word", pipe_enq_v, exp_w[idx]);
        idx++;
      end
      tick();
      if (pushed) nxt++;
    end
    echo__ENA = 1'b0;
    chk("sim_len", 32'(idx), 32'd20);
    settle();
    chk("sim_cnt", msg_count, 32'd10);

    // reset while in DATA with entries queued
    do_reset();
    push(32'd1);
    push(32'd2);
    push(32'd3);
    pipe_enq__RDY = 1'b1;
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    settle();
    chk("mr_rdy", 32'(echo__RDY), 32'd1);
    chk("mr_ena", 32'(pipe_enq__ENA), 32'd0);
    chk("mr_cnt", msg_count, 32'd0);
    push(32'hA5A5A5A5);
    settle();
    chk("mr_hdr_ena", 32'(pipe_enq__ENA), 32'd1);
    chk("mr_hdr", pipe_enq_v, HW);
    tick();
    settle();
    chk("mr_dat", pipe_enq_v, 32'hA5A5A5A5);
    tick();
    settle();
    chk("mr_cnt1", msg_count, 32'd1);

    // msg_count wrap
    do_reset();
    settle();
    dut.msg_cnt_q = 32'hFFFF_FFFF;
    settle();
    chk("wrap_pre", msg_count, 32'hFFFF_FFFF);
    pipe_enq__RDY = 1'b1;
    push(32'h0000_0042);
    tick();
    tick();
    settle();
    chk("wrap_cnt", msg_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d exp %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/echo_indication_portal.md
Name: echo_indication_portal

Overview:
- Downstream stage of the echo responder.
- Accepts echo(v) method calls on an ENA/RDY interface and buffers the 32-bit payloads in a DEPTH-entry FIFO.
- Marshals each payload into a two-word message (header, payload) and drives it through an enq method call into the host-bound pipe.
- Decouples the responder's rule firing from host back-pressure.

Parameters:
- DEPTH, 4, payload FIFO entries; power of two, at least 2.
- METHOD_ID, 16'h0001, indication method number placed in header bits [31:16].

Ports:
- CLK  input  1  clock; all state updates on posedge.
- nRST  input  1  reset; synchronous, active-low.
- echo__RDY  output  1  high when the FIFO can accept a payload.
- echo__ENA  input  1  echo call; sampled only when echo__RDY is high.
- echo_v  input  32  echo payload.
- pipe_enq__RDY  input  1  downstream pipe can accept a word this cycle.
- pipe_enq__ENA  output  1  word transferred this cycle.
- pipe_enq_v  output  32  word being transferred.
- msg_count  output  32  number of complete messages sent; wraps modulo 2^32.

Behaviour:
- Clock and reset: one clock CLK. Reset is synchronous, active-low (nRST sampled at posedge).
- Reset values:
  - FIFO empty (wr_ptr = rd_ptr = count = 0).
  - state = HDR.
  - msg_count = 0.
  - Therefore echo__RDY = 1, pipe_enq__ENA = 0, pipe_enq_v = 0.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap naturally, plus a count register of log2(DEPTH)+1 bits.
  - echo__RDY = (count != DEPTH), combinational from registers.
  - Enqueue when echo__ENA && echo__RDY: store echo_v at wr_ptr, wr_ptr+1.
  - echo__ENA while echo__RDY is low is ignored; no state change.
  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Legal whenever count in 1..DEPTH-1.
  - At count = 0 a dequeue is impossible, so enqueue only.
- Serializer FSM, two states:
  - HDR:
    - active = (count != 0).
    - pipe_enq_v = {METHOD_ID, 16'd2}; length field counts words including the header.
    - On transfer, go to DATA. FIFO is not popped.
  - DATA:
    - active = 1.
    - pipe_enq_v = FIFO head (mem[rd_ptr]).
    - On transfer: pop the FIFO, msg_count+1, go to HDR.
- Outputs:
  - pipe_enq__ENA = active && pipe_enq__RDY (combinational). A transfer is any cycle with pipe_enq__ENA high.
  - When not active, pipe_enq_v = 0.
- Latency:
  - A payload accepted on cycle N is visible at the FIFO head on N+1.
  - Header can transfer on N+1 and payload on N+2.
  - With continuous pipe_enq__RDY, sustained throughput is one message per 2 cycles.
- Back-pressure:
  - pipe_enq__RDY low holds the state, the words and the FIFO.
  - The header word stays stable until transferred; no words are dropped or duplicated.
- Ordering: messages leave in echo acceptance order. A header is always immediately followed (in transfer order) by its own payload.
- Reset mid-message (in DATA): the message is abandoned and the FIFO is flushed. The next message after reset starts with a header.
- msg_count wraps from 32'hFFFFFFFF to 0 with no flag.

Test Plan:
- Reset, then echo 32'hDEADBEEF on cycle 1 with pipe_enq__RDY=1:
  - cycle 2: ENA=1, v=32'h00010002.
  - cycle 3: ENA=1, v=32'hDEADBEEF.
  - msg_count = 1 after cycle 3.
- Fill with pipe_enq__RDY=0: enqueue 1,2,3,4.
  - echo__RDY drops after the 4th; a 5th ENA (value 5) is ignored.
  - Raise RDY: stream is hdr,1,hdr,2,hdr,3,hdr,4; msg_count = 4; value 5 never appears.
- Back-pressure mid-message: after header transfer of 32'h12345678, hold RDY=0 for 3 cycles.
  - pipe_enq__ENA = 0 throughout.
  - After RDY=1 the next word is 32'h12345678, transferred once.
- Simultaneous enq/deq at count=2 in DATA with RDY=1: count stays 2, pointers wrap correctly past DEPTH-1. Checked over 10 consecutive messages, values 0..9 in order.
- nRST=0 asserted while in DATA with 3 entries queued:
  - next cycle echo__RDY=1, pipe_enq__ENA=0, msg_count=0.
  - new echo 32'hA5A5A5A5 yields header then 32'hA5A5A5A5.
- Force msg_count to 32'hFFFFFFFF (preload via bench), send one message → msg_count = 0.
